tcp_rx_msg_gen: RTL and testbench
=================================

// Module: tcp_rx_msg_gen
// PURPOSE
//  Receive-side classifier between the TCP header parser and tcp_state_manager. Accepts parsed
//  segment headers, filters by port/seq/ack, maps flags to tcp_pkg::rx_msg_t events, and queues
//  them in a small FIFO drained by the state manager's valid/ack handshake. Tracks RCV.NXT for tx.
// PARAMETERS
//  MSG_DEPTH   2   message FIFO entries (power of two, >=2)
//  CNT_W       16  width of saturating drop counter
// PORTS
//  i_clk            in   1      clock
//  i_rst            in   1      reset, synchronous, active-high
//  i_enable         in   1      0 = connection disabled: flush, stop accepting
//  i_seg_valid      in   1      parsed header valid
//  o_seg_ready      out  1      header accepted when valid & ready
//  i_seg_flags      in   8      TCP flags {CWR,ECE,URG,ACK,PSH,RST,SYN,FIN} (bit0=FIN)
//  i_seg_seq        in   32     sequence number
//  i_seg_ack        in   32     acknowledgement number
//  i_seg_src_port   in   16     source port
//  i_seg_dst_port   in   16     destination port
//  i_seg_len        in   16     payload length, bytes
//  i_local_port     in   16     our port (config, static while enabled)
//  i_remote_port    in   16     peer port (config)
//  i_snd_nxt        in   32     SND.NXT from tx side
//  o_rx_msg         out  rx_msg_t  head-of-FIFO message
//  o_rx_msg_valid   out  1      FIFO non-empty
//  i_rx_msg_ack     in   1      pop head when valid & ack
//  o_rcv_nxt        out  32     RCV.NXT
//  o_rcv_nxt_valid  out  1      RCV.NXT synchronised (set by SYNACK)
//  o_drop_count     out  CNT_W  dropped segments, saturating
// BEHAVIOUR
//  Reset: o_rx_msg=RX_MSG_NOP, o_rx_msg_valid=0, o_rcv_nxt=0, o_rcv_nxt_valid=0, o_drop_count=0,
//   FIFO empty. o_seg_ready=0 during reset and whenever ~i_enable.
//  o_seg_ready = i_enable & ~fifo_full (combinational from occupancy, no pop bypass: full with
//   ack in same cycle still gives ready=0).
//  Classification, evaluated on accept cycle, first match wins:
//   1 dst_port!=i_local_port or src_port!=i_remote_port -> drop
//   2 RST set -> drop
//   3 SYN&ACK, ack==i_snd_nxt -> RX_MSG_RECV_SYNACK; rcv_nxt<=seq+1; rcv_nxt_valid<=1
//   4 SYN any other combination -> drop
//   5 ~rcv_nxt_valid or seq!=rcv_nxt -> drop (out-of-order/unsynchronised)
//   6 FIN -> RX_MSG_RECV_FIN; rcv_nxt<=seq+len+1
//   7 ACK -> RX_MSG_RECV_ACK; rcv_nxt<=seq+len (len may be 0)
//   8 otherwise -> drop
//  All 32-bit sums wrap modulo 2^32; len zero-extended.
//  Drop: no FIFO write, rcv_nxt unchanged, drop_count+1 saturating at all-ones.
//  Latency: header accepted at edge N -> message visible (o_rx_msg_valid=1) after edge N,
//   when FIFO was empty. o_rcv_nxt updates at same edge.
//  FIFO: first-word-fall-through; o_rx_msg=RX_MSG_NOP when empty. Push and pop in same cycle
//   (not full) keeps occupancy; order strictly preserved. Ack while ~valid ignored.
//  Enable falling (i_enable=0, sampled at edge): FIFO flushed, rcv_nxt_valid<=0, rcv_nxt<=0;
//   drop_count held. In-flight header on that cycle not accepted (ready already 0).
//  Reset mid-operation: all state returns to reset values at that edge.
// TESTING
//  Ports match, SYN|ACK seq=0x1000 ack=snd_nxt=0x5001 -> next cycle valid, SYNACK; rcv_nxt=0x1001.
//  After sync, ACK seq=0x1001 len=100 -> RECV_ACK; rcv_nxt=0x1065; FIN|ACK seq=0x1065 -> RECV_FIN, 0x1066.
//  SYN|ACK with ack=0x5000 (snd_nxt 0x5001), RST segment, wrong dst port -> no msgs, drop_count=3.
//  Hold ack=0, push 2 ACKs (MSG_DEPTH=2) -> ready=0; 3rd header stalls; ack once -> ready=1, order kept.
//  rcv_nxt=0xFFFFFFF0, ACK seq=0xFFFFFFF0 len=0x20 -> rcv_nxt=0x00000010 (wrap).
//  Deassert i_enable with 2 msgs queued -> valid=0, rcv_nxt_valid=0 next cycle; drop_count unchanged.

Source files
------------

// File: rtl/tcp_rx_msg_gen.sv
// Receive-side segment classifier: filters parsed TCP headers, maps flags to rx_msg_t
// events queued in a small first-word-fall-through FIFO, and tracks RCV.NXT.
package tcp_pkg;
  typedef enum logic [1:0] {
    RX_MSG_NOP         = 2'd0,
    RX_MSG_RECV_SYNACK = 2'd1,
    RX_MSG_RECV_ACK    = 2'd2,
    RX_MSG_RECV_FIN    = 2'd3
  } rx_msg_t;
endpackage

module tcp_rx_msg_gen
  import tcp_pkg::*;
#(
  parameter int MSG_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_seg_valid,
  output logic             o_seg_ready,
  input  logic [7:0]       i_seg_flags,
  input  logic [31:0]      i_seg_seq,
  input  logic [31:0]      i_seg_ack,
  input  logic [15:0]      i_seg_src_port,
  input  logic [15:0]      i_seg_dst_port,
  input  logic [15:0]      i_seg_len,
  input  logic [15:0]      i_local_port,
  input  logic [15:0]      i_remote_port,
  input  logic [31:0]      i_snd_nxt,
  output rx_msg_t          o_rx_msg,
  output logic             o_rx_msg_valid,
  input  logic             i_rx_msg_ack,
  output logic [31:0]      o_rcv_nxt,
  output logic             o_rcv_nxt_valid,
  output logic [CNT_W-1:0] o_drop_count
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    OCC_FULL = (AW + 1)'(MSG_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam int FIN_BIT = 0;
  localparam int SYN_BIT = 1;
  localparam int RST_BIT = 2;
  localparam int ACK_BIT = 4;

  rx_msg_t          msg_mem_reg [MSG_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [31:0]      rcv_nxt_reg, rcv_nxt_next;
  logic             rcv_nxt_valid_reg, rcv_nxt_valid_next;
  logic [CNT_W-1:0] drop_count_reg;

  logic    fifo_full, fifo_empty, accept, pop, push, drop;
  rx_msg_t msg_next;
  logic [31:0] seq_plus_len;

  assign fifo_full    = (count_reg == OCC_FULL);
  assign fifo_empty   = (count_reg == '0);
  // Ready looks only at current occupancy; a same-cycle pop does not open a slot.
  assign o_seg_ready  = i_enable & ~i_rst & ~fifo_full;
  assign accept       = i_seg_valid & o_seg_ready;
  assign pop          = i_rx_msg_ack & ~fifo_empty;
  assign seq_plus_len = i_seg_seq + {16'd0, i_seg_len};

  always_comb begin
    push               = 1'b0;
    drop               = 1'b0;
    msg_next           = RX_MSG_NOP;
    rcv_nxt_next       = rcv_nxt_reg;
    rcv_nxt_valid_next = rcv_nxt_valid_reg;
    if (accept) begin
      if (i_seg_dst_port != i_local_port || i_seg_src_port != i_remote_port) begin
        drop = 1'b1;
      end else if (i_seg_flags[RST_BIT]) begin
        drop = 1'b1;
      end else if (i_seg_flags[SYN_BIT]) begin
        if (i_seg_flags[ACK_BIT] && i_seg_ack == i_snd_nxt) begin
          push               = 1'b1;
          msg_next           = RX_MSG_RECV_SYNACK;
          rcv_nxt_next       = i_seg_seq + 32'd1;
          rcv_nxt_valid_next = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (!rcv_nxt_valid_reg || i_seg_seq != rcv_nxt_reg) begin
        drop = 1'b1;
      end else if (i_seg_flags[FIN_BIT]) begin
        push         = 1'b1;
        msg_next     = RX_MSG_RECV_FIN;
        rcv_nxt_next = seq_plus_len + 32'd1;
      end else if (i_seg_flags[ACK_BIT]) begin
        push         = 1'b1;
        msg_next     = RX_MSG_RECV_ACK;
        rcv_nxt_next = seq_plus_len;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      rcv_nxt_reg       <= '0;
      rcv_nxt_valid_reg <= 1'b0;
      drop_count_reg    <= '0;
    end else if (!i_enable) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      rcv_nxt_reg       <= '0;
      rcv_nxt_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + OCC_ONE;
      else if (pop && !push) count_reg <= count_reg - OCC_ONE;
      rcv_nxt_reg       <= rcv_nxt_next;
      rcv_nxt_valid_reg <= rcv_nxt_valid_next;
      if (drop && drop_count_reg != '1) drop_count_reg <= drop_count_reg + CNT_ONE;
    end
  end

  // Payload storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge i_clk) begin
    if (push) msg_mem_reg[wr_ptr_reg] <= msg_next;
  end

  assign o_rx_msg        = fifo_empty ? RX_MSG_NOP : msg_mem_reg[rd_ptr_reg];
  assign o_rx_msg_valid  = ~fifo_empty;
  assign o_rcv_nxt       = rcv_nxt_reg;
  assign o_rcv_nxt_valid = rcv_nxt_valid_reg;
  assign o_drop_count    = drop_count_reg;

endmodule

// File: tb/tb_tcp_rx_msg_gen.sv
// Directed and randomized bench for tcp_rx_msg_gen against a queue-based reference model.
module tb_tcp_rx_msg_gen;
  import tcp_pkg::*;

  localparam int DEPTH  = 2;
  localparam int CNT_W  = 16;
  localparam logic [15:0] LPORT = 16'h1234;
  localparam logic [15:0] RPORT = 16'h5678;
  localparam logic [31:0] SNDNX = 32'h0000_5001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, seg_valid, seg_ready, msg_ack, rcv_v;
  logic [7:0]       flags;
  logic [31:0]      seq, ack_num, rcv_nxt;
  logic [15:0]      src, dst, len;
  rx_msg_t          rx_msg;
  logic             rx_valid;
  logic [CNT_W-1:0] drop_cnt;

  tcp_rx_msg_gen #(.MSG_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .i_seg_valid(seg_valid), .o_seg_ready(seg_ready),
    .i_seg_flags(flags), .i_seg_seq(seq), .i_seg_ack(ack_num),
    .i_seg_src_port(src), .i_seg_dst_port(dst), .i_seg_len(len),
    .i_local_port(LPORT), .i_remote_port(RPORT), .i_snd_nxt(SNDNX),
    .o_rx_msg(rx_msg), .o_rx_msg_valid(rx_valid), .i_rx_msg_ack(msg_ack),
    .o_rcv_nxt(rcv_nxt), .o_rcv_nxt_valid(rcv_v), .o_drop_count(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          q[$];
  logic [31:0] m_rcv = 32'd0;
  bit          m_rcv_v = 1'b0;
  int          m_drops = 0;

  // Returns message code (0 = drop) and the new RCV.NXT by the first-match rules.
  function automatic int classify(output logic [31:0] nr);
    nr = m_rcv;
    if (dst != LPORT || src != RPORT) return 0;
    if (flags[2]) return 0;
    if (flags[1]) begin
      if (flags[4] && ack_num == SNDNX) begin nr = seq + 32'd1; return int'(RX_MSG_RECV_SYNACK); end
      return 0;
    end
    if (!m_rcv_v || seq != m_rcv) return 0;
    if (flags[0]) begin nr = seq + 32'(len) + 32'd1; return int'(RX_MSG_RECV_FIN); end
    if (flags[4]) begin nr = seq + 32'(len); return int'(RX_MSG_RECV_ACK); end
    return 0;
  endfunction

  task automatic model_step();
    bit          do_pop, acc;
    int          m;
    logic [31:0] nr;
    if (rst) begin
      q.delete(); m_rcv = 0; m_rcv_v = 0; m_drops = 0;
    end else if (!en) begin
      q.delete(); m_rcv = 0; m_rcv_v = 0;
    end else begin
      do_pop = msg_ack && q.size() > 0;
      acc    = seg_valid && q.size() < DEPTH;
      m      = 0;
      nr     = m_rcv;
      if (acc) m = classify(nr);
      if (do_pop) void'(q.pop_front());
      if (acc) begin
        if (m == 0) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          q.push_back(m);
          m_rcv   = nr;
          m_rcv_v = 1'b1;
        end
        $display("seg flags=%02h seq=%08h len=%0d -> msg %0d rcv_nxt=%08h", flags, seq, len, m, m_rcv);
      end
    end
  endtask

  task automatic check_all();
    check_eq("ready", 32'(seg_ready), 32'(!rst && en && q.size() < DEPTH));
    check_eq("valid", 32'(rx_valid), 32'(q.size() > 0));
    check_eq("msg", 32'(rx_msg), (q.size() > 0) ? 32'(q[0]) : 32'(RX_MSG_NOP));
    check_eq("rcv_nxt", rcv_nxt, m_rcv);
    check_eq("rcv_v", 32'(rcv_v), 32'(m_rcv_v));
    check_eq("drops", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic seg(input logic v, input logic [7:0] f, input logic [31:0] s,
                     input logic [15:0] l, input logic a);
    seg_valid = v; flags = f; seq = s; len = l; msg_ack = a;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; seg_valid = 1'b0; msg_ack = 1'b0;
    flags = 8'h00; seq = 32'd0; len = 16'd0;
    ack_num = SNDNX; src = RPORT; dst = LPORT;
    tick(); tick();
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_ready", 32'(seg_ready), 32'd0);
    rst = 1'b0;

    // Handshake and in-order data
    seg(1, 8'h12, 32'h1000, 16'd0, 0);
    check_eq("synack_msg", 32'(rx_msg), 32'(RX_MSG_RECV_SYNACK));
    check_eq("synack_rcv", rcv_nxt, 32'h1001);
    seg(0, 8'h00, 32'h0, 16'd0, 1);
    seg(1, 8'h10, 32'h1001, 16'd100, 0);
    check_eq("ack_msg", 32'(rx_msg), 32'(RX_MSG_RECV_ACK));
    check_eq("ack_rcv", rcv_nxt, 32'h1065);
    seg(0, 8'h00, 32'h0, 16'd0, 1);
    seg(1, 8'h11, 32'h1065, 16'd0, 0);
    check_eq("fin_msg", 32'(rx_msg), 32'(RX_MSG_RECV_FIN));
    check_eq("fin_rcv", rcv_nxt, 32'h1066);
    seg(0, 8'h00, 32'h0, 16'd0, 1);

    // Three drops: bad ack, RST, wrong destination port
    ack_num = 32'h5000;
    seg(1, 8'h12, 32'h2000, 16'd0, 0);
    ack_num = SNDNX;
    seg(1, 8'h04, 32'h1066, 16'd0, 0);
    dst = 16'h9999;
    seg(1, 8'h10, 32'h1066, 16'd0, 0);
    dst = LPORT;
    seg(0, 8'h00, 32'h0, 16'd0, 0);
    check_eq("drop3_cnt", 32'(drop_cnt), 32'd3);
    check_eq("drop3_valid", 32'(rx_valid), 32'd0);

    // Fill FIFO, stall, release with one pop
    seg(1, 8'h10, 32'h1066, 16'd0, 0);
    seg(1, 8'h10, 32'h1066, 16'd0, 0);
    check_eq("full_ready", 32'(seg_ready), 32'd0);
    seg(1, 8'h10, 32'h1066, 16'd4, 0);
    check_eq("stall_rcv", rcv_nxt, 32'h1066);
    seg(1, 8'h10, 32'h1066, 16'd4, 1);
    check_eq("after_pop_ready", 32'(seg_ready), 32'd1);
    seg(1, 8'h10, 32'h1066, 16'd4, 0);
    check_eq("third_rcv", rcv_nxt, 32'h106A);
    seg(0, 8'h00, 32'h0, 16'd0, 1);
    seg(0, 8'h00, 32'h0, 16'd0, 1);

    // Sequence wrap
    seg(1, 8'h12, 32'hFFFF_FFEF, 16'd0, 0);
    check_eq("pre_wrap_rcv", rcv_nxt, 32'hFFFF_FFF0);
    seg(1, 8'h10, 32'hFFFF_FFF0, 16'h0020, 0);
    check_eq("wrap_rcv", rcv_nxt, 32'h0000_0010);

    // Disable with two messages queued
    en = 1'b0;
    seg(0, 8'h00, 32'h0, 16'd0, 0);
    check_eq("dis_valid", 32'(rx_valid), 32'd0);
    check_eq("dis_rcv_v", 32'(rcv_v), 32'd0);
    check_eq("dis_drops", 32'(drop_cnt), 32'd3);
    en = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0]  f;
      logic [31:0] s;
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 7))
        0:       f = 8'h12;
        1, 2:    f = 8'h10;
        3:       f = 8'h11;
        4:       f = 8'h01;
        5:       f = 8'h04;
        6:       f = 8'h02;
        default: f = 8'($urandom_range(0, 255));
      endcase
      s       = ($urandom_range(0, 9) < 7) ? m_rcv : 32'($urandom);
      ack_num = ($urandom_range(0, 9) < 7) ? SNDNX : 32'($urandom);
      src     = ($urandom_range(0, 19) == 0) ? 16'($urandom) : RPORT;
      dst     = ($urandom_range(0, 19) == 0) ? 16'($urandom) : LPORT;
      seg(1'($urandom_range(0, 1)), f, s, 16'($urandom_range(0, 3000)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
